two_phase_latch_sequencer: RTL and testbench

TWO_PHASE_LATCH_SEQUENCER -- requirements
Module: two_phase_latch_sequencer

---
 rtl/two_phase_latch_sequencer.sv | 138 +++++++++++++
 tb/tb_two_phase_latch_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/two_phase_latch_sequencer.sv
// rtl/two_phase_latch_sequencer.sv - non-overlapping master/slave latch enable sequencer
// Optional completed-cycle counter enabled by TWO_PHASE_SEQ_CYCLE_COUNT_EN.
module two_phase_latch_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [CNT_W-1:0] phase_len,
  input  logic [CNT_W-1:0] gap_len,
  output logic             en_m,
  output logic             en_s,
  output logic             busy,
  output logic             cycle_done,
  output logic [7:0]       cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MASTER,
    S_GAP1,
    S_SLAVE,
    S_GAP2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] g_q, g_d;

  logic [CNT_W-1:0] p_last;
  logic [CNT_W-1:0] g_last;
  logic             p_done;
  logic             g_done;
  logic             g_zero;
  logic             end_of_cycle;

  // A latched phase length of 0 dwells one clock, same as 1.
  assign p_last = (p_q == '0) ? '0 : p_q - CNT_W'(1);
  assign g_last = g_q - CNT_W'(1);
  assign p_done = (cnt_q == p_last);
  assign g_done = (cnt_q == g_last);
  assign g_zero = (g_q == '0);

  assign end_of_cycle = ((state_q == S_GAP2) && g_done) ||
                        ((state_q == S_SLAVE) && p_done && g_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      g_q     <= g_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    p_d     = p_q;
    g_d     = g_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (run || step) begin
          state_d = S_MASTER;
          p_d     = phase_len;
          g_d     = gap_len;
        end
      end
      S_MASTER: begin
        if (p_done) begin
          cnt_d   = '0;
          state_d = g_zero ? S_SLAVE : S_GAP1;
        end
      end
      S_GAP1: begin
        if (g_done) begin
          cnt_d   = '0;
          state_d = S_SLAVE;
        end
      end
      S_SLAVE: begin
        if (p_done) begin
          cnt_d = '0;
          if (!g_zero) state_d = S_GAP2;
        end
      end
      S_GAP2: begin
        if (g_done) cnt_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Cycle boundary: only run is honoured here, so a step-started cycle parks in IDLE.
    if (end_of_cycle) begin
      cnt_d = '0;
      if (run) begin
        state_d = S_MASTER;
        p_d     = phase_len;
        g_d     = gap_len;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  assign en_m       = (state_q == S_MASTER);
  assign en_s       = (state_q == S_SLAVE);
  assign busy       = (state_q != S_IDLE);
  assign cycle_done = end_of_cycle;

`ifdef TWO_PHASE_SEQ_CYCLE_COUNT_EN
  logic [7:0] cycle_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
    end else if (end_of_cycle) begin
      cycle_cnt_q <= cycle_cnt_q + 8'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_two_phase_latch_sequencer.sv
// tb/tb_two_phase_latch_sequencer.sv - directed self-checking bench for two_phase_latch_sequencer
module tb_two_phase_latch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       step;
  logic [3:0] phase_len;
  logic [3:0] gap_len;
  logic       en_m;
  logic       en_s;
  logic       busy;
  logic       cycle_done;
  logic [7:0] cycle_cnt;

  int pass_cnt = 0;
  int total    = 0;
  int exp_cycles = 0;
  logic overlap_seen = 1'b0;

  two_phase_latch_sequencer #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .phase_len  (phase_len),
    .gap_len    (gap_len),
    .en_m       (en_m),
    .en_s       (en_s),
    .busy       (busy),
    .cycle_done (cycle_done),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [7:0] exp_cc(input int n);
`ifdef TWO_PHASE_SEQ_CYCLE_COUNT_EN
    return 8'(n % 256);
`else
    return 8'd0;
`endif
  endfunction

  // Each table entry is {en_m, en_s, busy, cycle_done}, first tick in the most significant nibble.
  task automatic run_table(input string tag, input int n, input logic [63:0] tab,
                           input int run_off_at, input int p_set_at, input logic [3:0] p_new);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      tick();
      e = tab[4*(n-1-i) +: 4];
      chk($sformatf("%s[%0d]", tag, i), {28'd0, en_m, en_s, busy, cycle_done}, {28'd0, e});
      if (i == 0) step = 1'b0;
      if (i == run_off_at) run = 1'b0;
      if (i == p_set_at) phase_len = p_new;
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; step = 1'b1; phase_len = 4'd2; gap_len = 4'd1;
    tick();
    tick();
    chk("reset_outputs", {28'd0, en_m, en_s, busy, cycle_done}, 32'd0);
    chk("reset_cnt", {24'd0, cycle_cnt}, 32'd0);

    // Single step, P=2 G=1, started on the first edge without reset.
    rst = 1'b0; run = 1'b0; step = 1'b1;
    run_table("step_p2g1", 7,
              {4'b1010, 4'b1010, 4'b0010, 4'b0110, 4'b0110, 4'b0011, 4'b0000},
              -1, -1, 4'd0);
    exp_cycles += 1;
    chk("step_cnt", {24'd0, cycle_cnt}, {24'd0, exp_cc(exp_cycles)});

    // Continuous run, P=1 G=0: back-to-back alternation.
    phase_len = 4'd1; gap_len = 4'd0; run = 1'b1;
    run_table("run_p1g0", 9,
              {4'b1010, 4'b0111, 4'b1010, 4'b0111, 4'b1010, 4'b0111, 4'b1010, 4'b0111, 4'b0000},
              7, -1, 4'd0);
    exp_cycles += 4;
    chk("run_p1g0_cnt", {24'd0, cycle_cnt}, {24'd0, exp_cc(exp_cycles)});

    // run dropped during SLAVE does not truncate the 10-clock cycle.
    phase_len = 4'd3; gap_len = 4'd2; run = 1'b1;
    run_table("drop_run", 11,
              {4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0110,
               4'b0010, 4'b0011, 4'b0000},
              5, -1, 4'd0);
    exp_cycles += 1;
    chk("drop_run_cnt", {24'd0, cycle_cnt}, {24'd0, exp_cc(exp_cycles)});

    // phase_len 3->1 mid-cycle only takes effect at the next latch point.
    phase_len = 4'd3; gap_len = 4'd0; run = 1'b1;
    run_table("plen_chg", 9,
              {4'b1010, 4'b1010, 4'b1010, 4'b0110, 4'b0110, 4'b0111, 4'b1010, 4'b0111, 4'b0000},
              7, 0, 4'd1);
    exp_cycles += 2;
    chk("plen_chg_cnt", {24'd0, cycle_cnt}, {24'd0, exp_cc(exp_cycles)});

    // Reset while in GAP1.
    phase_len = 4'd1; gap_len = 4'd2; step = 1'b1;
    tick();
    step = 1'b0;
    chk("rst_pre_master", {28'd0, en_m, en_s, busy, cycle_done}, 32'b1010);
    tick();
    chk("rst_pre_gap1", {28'd0, en_m, en_s, busy, cycle_done}, 32'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cycles = 0;
    chk("rst_gap1_outputs", {28'd0, en_m, en_s, busy, cycle_done}, 32'd0);
    chk("rst_gap1_cnt", {24'd0, cycle_cnt}, 32'd0);

    // 256 cycles of P=1 G=0: counter wraps 255->0.
    phase_len = 4'd1; gap_len = 4'd0; run = 1'b1;
    for (int i = 0; i <= 512; i++) begin
      tick();
      if (en_m && en_s) overlap_seen = 1'b1;
      if (i == 510) chk("wrap_255", {24'd0, cycle_cnt}, {24'd0, exp_cc(255)});
      if (i == 512) chk("wrap_0", {24'd0, cycle_cnt}, {24'd0, exp_cc(256)});
    end
    chk("no_overlap", {31'd0, overlap_seen}, 32'd0);
    chk("wrap_en_m_phase", {31'd0, en_m}, 32'd1);
    run = 1'b0;
    tick();
    chk("wrap_last_slave", {28'd0, en_m, en_s, busy, cycle_done}, 32'b0111);
    tick();
    chk("wrap_idle", {28'd0, en_m, en_s, busy, cycle_done}, 32'd0);
    chk("wrap_final_cnt", {24'd0, cycle_cnt}, {24'd0, exp_cc(257)});

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
